// File: rtl/alu_share_if.sv
// Handshake bundle between two ALU requesters, the response consumer and the
// shared ALU controller. The master side drives requests and consumes responses.
interface alu_share_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [31:0] req0_a;
  logic [31:0] req0_b;
  logic [1:0]  req0_ctrl;
  logic        req0_setflags;

  logic        req1_valid;
  logic        req1_ready;
  logic [31:0] req1_a;
  logic [31:0] req1_b;
  logic [1:0]  req1_ctrl;
  logic        req1_setflags;

  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [31:0] rsp_result;
  logic [3:0]  rsp_flags;
  logic [3:0]  flags_q;

  modport master (
    output req0_valid, req0_a, req0_b, req0_ctrl, req0_setflags,
    output req1_valid, req1_a, req1_b, req1_ctrl, req1_setflags,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_result, rsp_flags, flags_q
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_ctrl, req0_setflags,
    input  req1_valid, req1_a, req1_b, req1_ctrl, req1_setflags,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_result, rsp_flags, flags_q
  );
endinterface

// File: rtl/alu_share_ctrl.sv
// Two-requester front end around a single shared 32-bit ALU. Round-robin grant,
// one-entry registered response, architectural NZCV register.

// 32-bit ALU: 00 add, 01 sub, 10 and, 11 or. Flags {N,Z,C,V}.
// For subtract, C reports a borrow (a < b unsigned); C/V are 0 for logic ops.
module alu (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [1:0]  ctrl_i,
  output logic [31:0] result_o,
  output logic [3:0]  flags_o
);
  logic [32:0] sum;
  logic        arith;
  logic        c;
  logic        v;

  // a + b or a + ~b + 1 depending on the subtract bit
  assign sum   = {1'b0, a_i} + {1'b0, (ctrl_i[0] ? ~b_i : b_i)} + {32'd0, ctrl_i[0]};
  assign arith = ~ctrl_i[1];
  assign c     = arith & (sum[32] ^ ctrl_i[0]);
  assign v     = arith & ~(ctrl_i[0] ^ a_i[31] ^ b_i[31]) & (a_i[31] ^ sum[31]);

  // Result select
  always_comb begin
    result_o = sum[31:0];
    case (ctrl_i)
      2'b10:   result_o = a_i & b_i;
      2'b11:   result_o = a_i | b_i;
      default: result_o = sum[31:0];
    endcase
  end

  assign flags_o = {result_o[31], (result_o == 32'd0), c, v};
endmodule

module alu_share_ctrl (
  input  logic      clk,
  input  logic      reset,
  alu_share_if.slave bus
);
  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t      state_q;
  logic        rsp_valid_q;
  logic        rsp_id_q;
  logic [31:0] rsp_result_q;
  logic [3:0]  rsp_flags_q;
  logic [3:0]  arch_flags_q;
  logic        last_grant_q;

  // Requesters gathered into packed arrays so the grant can index them
  logic [1:0]        req_valid;
  logic [1:0][31:0]  req_a;
  logic [1:0][31:0]  req_b;
  logic [1:0][1:0]   req_ctrl;
  logic [1:0]        req_sf;

  assign req_valid = {bus.req1_valid,    bus.req0_valid};
  assign req_a     = {bus.req1_a,        bus.req0_a};
  assign req_b     = {bus.req1_b,        bus.req0_b};
  assign req_ctrl  = {bus.req1_ctrl,     bus.req0_ctrl};
  assign req_sf    = {bus.req1_setflags, bus.req0_setflags};

  logic rsp_hs;
  logic accept_en;
  logic gnt_any;
  logic gnt_id;
  logic accept;

  assign rsp_hs    = rsp_valid_q & bus.rsp_ready;
  // Reset gates acceptance so nothing can handshake while reset is held
  assign accept_en = ~reset & ((state_q == IDLE) | rsp_hs);
  assign gnt_any   = |req_valid;
  // Tie goes to whoever did not win last; otherwise the lone valid requester
  assign gnt_id    = (&req_valid) ? ~last_grant_q : req_valid[1];
  assign accept    = accept_en & gnt_any;

  assign bus.req0_ready = accept & ~gnt_id;
  assign bus.req1_ready = accept &  gnt_id;

  // Single shared ALU, operands steered by the current grant
  logic [31:0] alu_result;
  logic [3:0]  alu_flags;

  alu u_alu (
    .a_i      (req_a[gnt_id]),
    .b_i      (req_b[gnt_id]),
    .ctrl_i   (req_ctrl[gnt_id]),
    .result_o (alu_result),
    .flags_o  (alu_flags)
  );

  // Response FSM: capture on accept, release on consumer handshake
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= 32'd0;
      rsp_flags_q  <= 4'd0;
      arch_flags_q <= 4'd0;
      last_grant_q <= 1'b1;
    end else if (accept) begin
      state_q      <= BUSY;
      rsp_valid_q  <= 1'b1;
      rsp_id_q     <= gnt_id;
      rsp_result_q <= alu_result;
      rsp_flags_q  <= alu_flags;
      last_grant_q <= gnt_id;
      if (req_sf[gnt_id]) arch_flags_q <= alu_flags;
    end else if (rsp_hs) begin
      state_q      <= IDLE;
      rsp_valid_q  <= 1'b0;
    end
  end

  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_flags  = rsp_flags_q;
  assign bus.flags_q    = arch_flags_q;

  // Grants are exclusive
  a_gnt_onehot: assert property (@(posedge clk) disable iff (reset)
    !(bus.req0_ready && bus.req1_ready));

  // A stalled response does not move
  a_rsp_stable: assert property (@(posedge clk) disable iff (reset)
    (rsp_valid_q && !bus.rsp_ready) |=> (rsp_valid_q && $stable(rsp_result_q)
                                        && $stable(rsp_flags_q) && $stable(rsp_id_q)));
endmodule
